jtframe_dwnld_banks: RTL and testbench



---
 rtl/jtframe_dwnld_banks.sv | 212 +++++++++++++++++++++
 tb/tb_jtframe_dwnld_banks.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_dwnld_banks.sv
// jtframe_dwnld_banks
//   Bridge from the ioctl byte download stream to the SDRAM programming port.
//   Each accepted byte is tagged with its region (SDRAM bank 0..3 or PROM) and
//   its offset inside that region, then queued in a small FIFO. A three-state
//   machine drains the FIFO: SDRAM bytes become a held prog_we request that
//   waits for prog_rdy, while PROM bytes become a single-cycle prom_we strobe.
//
// Ports
//   clk, rst            clock and asynchronous active-high reset
//   downloading         ioctl download in progress (enables byte capture)
//   ioctl_addr/dout/wr  byte address, byte data, byte strobe
//   prog_addr           word address relative to the start of the bank
//   prog_data           byte duplicated on both lanes
//   prog_mask           active-low byte enables
//   prog_ba             SDRAM bank select
//   prog_we / prog_rdy  write request held until the one-cycle acknowledge
//   prom_we             one-cycle PROM write strobe (uses prog_addr/prog_data)
//   dwnld_busy          download active or data still draining
//   ovf                 sticky FIFO overflow, cleared when a download starts
module jtframe_dwnld_banks #(
   parameter int          SDRAMW     = 22,
   parameter int          BANKS      = 4,
   parameter logic [24:0] BA1_START  = 25'h100000,
   parameter logic [24:0] BA2_START  = 25'h200000,
   parameter logic [24:0] BA3_START  = 25'h300000,
   parameter logic [24:0] PROM_START = 25'h1F00000,
   parameter int          SWAB       = 0,
   parameter int          AW         = 3
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              downloading,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic              ioctl_wr,
   output logic [SDRAMW-1:0] prog_addr,
   output logic [15:0]       prog_data,
   output logic [1:0]        prog_mask,
   output logic [1:0]        prog_ba,
   output logic              prog_we,
   input  logic              prog_rdy,
   output logic              prom_we,
   output logic              dwnld_busy,
   output logic              ovf
);

   // Only offset bits up to SDRAMW are ever used: [SDRAMW:1] is the word
   // address and bit 0 selects the byte lane.
   localparam int            OW    = SDRAMW + 1;
   localparam int            EW    = 3 + OW + 8;
   localparam logic [AW:0]   DEPTH = (AW+1)'(1 << AW);

   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_GAP} state_t;

   state_t          r_state, w_state_nxt;
   logic [EW-1:0]   r_mem [0:(1<<AW)-1];
   logic [AW-1:0]   r_wptr, r_rptr;
   logic [AW:0]     r_cnt;
   logic            r_dl_d;

   logic            w_prom_p0;
   logic [1:0]      w_bank_p0;
   logic [24:0]     w_start_p0;
   logic [OW-1:0]   w_offset_p0;
   logic [EW-1:0]   w_entry_p0;

   logic [EW-1:0]   w_entry_p1;
   logic            w_prom_p1;
   logic [1:0]      w_bank_p1;
   logic [OW-1:0]   w_offset_p1;
   logic [7:0]      w_byte_p1;

   logic            w_full, w_empty, w_push_req, w_push, w_pop, w_drop;
   logic            w_load_sdram, w_load_prom, w_we_nxt;

   function automatic logic [1:0] f_mask(input logic odd);
      logic [1:0] m;
      m = odd ? 2'b01 : 2'b10;
      return (SWAB != 0) ? ~m : m;
   endfunction

   // ---- p0: region decode of the incoming byte ----
   // Starts are strictly increasing, so the first match from the top is the
   // highest region whose start is not above the address.
   always_comb begin
      w_prom_p0  = 1'b0;
      w_bank_p0  = 2'd0;
      w_start_p0 = '0;
      if (ioctl_addr >= PROM_START) begin
         w_prom_p0  = 1'b1;
         w_start_p0 = PROM_START;
      end else if (BANKS > 3 && ioctl_addr >= BA3_START) begin
         w_bank_p0  = 2'd3;
         w_start_p0 = BA3_START;
      end else if (BANKS > 2 && ioctl_addr >= BA2_START) begin
         w_bank_p0  = 2'd2;
         w_start_p0 = BA2_START;
      end else if (BANKS > 1 && ioctl_addr >= BA1_START) begin
         w_bank_p0  = 2'd1;
         w_start_p0 = BA1_START;
      end
   end

   assign w_offset_p0 = OW'(ioctl_addr - w_start_p0);
   assign w_entry_p0  = {w_prom_p0, w_bank_p0, w_offset_p0, ioctl_dout};

   assign w_full     = (r_cnt == DEPTH);
   assign w_empty    = (r_cnt == '0);
   assign w_push_req = ioctl_wr & downloading;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push     = w_push_req & (~w_full | w_pop);
   assign w_drop     = w_push_req & w_full & ~w_pop;

   // ---- p1: FIFO storage and head entry ----
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_entry_p0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   assign w_entry_p1  = r_mem[r_rptr];
   assign w_prom_p1   = w_entry_p1[EW-1];
   assign w_bank_p1   = w_entry_p1[EW-2 -: 2];
   assign w_offset_p1 = w_entry_p1[8 +: OW];
   assign w_byte_p1   = w_entry_p1[7:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pop        = 1'b0;
      w_load_sdram = 1'b0;
      w_load_prom  = 1'b0;
      w_we_nxt     = prog_we;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               if (w_prom_p1) begin
                  w_load_prom = 1'b1;
               end else begin
                  w_load_sdram = 1'b1;
                  w_we_nxt     = 1'b1;
                  w_state_nxt  = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            if (prog_rdy) begin
               w_we_nxt    = 1'b0;
               w_state_nxt = ST_GAP;
            end
         end
         ST_GAP:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---- p2: registered programming-port outputs ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prog_we   <= 1'b0;
         prom_we   <= 1'b0;
         prog_addr <= '0;
         prog_data <= '0;
         prog_mask <= '0;
         prog_ba   <= '0;
      end else begin
         prog_we <= w_we_nxt;
         prom_we <= w_load_prom;
         if (w_load_sdram || w_load_prom) begin
            prog_addr <= w_offset_p1[SDRAMW:1];
            prog_data <= {2{w_byte_p1}};
         end
         if (w_load_sdram) begin
            prog_mask <= f_mask(w_offset_p1[0]);
            prog_ba   <= w_bank_p1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dl_d <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         r_dl_d <= downloading;
         if (downloading && !r_dl_d) ovf <= 1'b0;
         if (w_drop)                 ovf <= 1'b1;
      end
   end

   assign dwnld_busy = downloading | ~w_empty | (r_state != ST_IDLE);

endmodule

// File: tb/tb_jtframe_dwnld_banks.sv
module tb_jtframe_dwnld_banks;

  logic        clk = 1'b0;
  logic        rst, downloading, ioctl_wr, prog_rdy;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic [21:0] prog_addr, prog_addr1;
  logic [15:0] prog_data, prog_data1;
  logic [1:0]  prog_mask, prog_mask1, prog_ba, prog_ba1;
  logic        prog_we, prog_we1, prom_we, prom_we1;
  logic        dwnld_busy, dwnld_busy1, ovf, ovf1;

  always #5 clk = ~clk;

  jtframe_dwnld_banks u_dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_ba(prog_ba), .prog_we(prog_we), .prog_rdy(prog_rdy),
    .prom_we(prom_we), .dwnld_busy(dwnld_busy), .ovf(ovf)
  );

  jtframe_dwnld_banks #(.BANKS(1)) u_dut1 (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr1), .prog_data(prog_data1), .prog_mask(prog_mask1),
    .prog_ba(prog_ba1), .prog_we(prog_we1), .prog_rdy(prog_rdy),
    .prom_we(prom_we1), .dwnld_busy(dwnld_busy1), .ovf(ovf1)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        prom;
    logic [1:0]  ba;
    logic [21:0] paddr;
    logic [15:0] data;
    logic [1:0]  mask;
  } exp_t;

  typedef struct {
    logic [24:0] a;
    logic [7:0]  d;
    int          lat;
    logic        prom;
    logic [1:0]  ba;
    logic [21:0] pa;
    logic [1:0]  mask;
    logic [21:0] pa1;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: region and offset computed straight from the address map.
  function automatic exp_t ref_model(input logic [24:0] a, input logic [7:0] d, input int banks);
    int unsigned starts[4];
    int unsigned addr, off;
    exp_t e;
    starts = '{32'h0, 32'h100000, 32'h200000, 32'h300000};
    addr   = 32'(a);
    e.prom = 1'b0;
    e.ba   = 2'd0;
    off    = addr;
    if (addr >= 32'h1F00000) begin
      e.prom = 1'b1;
      off    = addr - 32'h1F00000;
    end else begin
      for (int n = 1; n < banks; n++)
        if (addr >= starts[n]) begin
          e.ba = 2'(n);
          off  = addr - starts[n];
        end
    end
    e.paddr = 22'((off / 2) % (32'd1 << 22));
    e.data  = {d, d};
    e.mask  = (off % 2 == 1) ? 2'b01 : 2'b10;
    return e;
  endfunction

  function automatic logic [24:0] rnd_addr();
    logic [24:0] b[8];
    b = '{25'h0FFFFF, 25'h100000, 25'h1FFFFF, 25'h200000,
          25'h2FFFFF, 25'h300000, 25'h1EFFFFF, 25'h1F00000};
    case ($urandom_range(0, 3))
      0:       return 25'($urandom);
      1:       return b[$urandom_range(0, 7)] + 25'($urandom_range(0, 3)) - 25'd2;
      2:       return 25'h1F00000 + 25'($urandom_range(0, 65535));
      default: return 25'($urandom_range(0, 32'h3FFFFF));
    endcase
  endfunction

  // Acknowledge a pending write so prog_we is seen high for 'lat' cycles.
  task automatic handshake(input int lat, output int hi);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      if (!prog_we) break;
      hi++;
      prog_rdy = (hi == lat);
      tick();
      prog_rdy = 1'b0;
    end
  endtask

  task automatic wait_we(output int cyc);
    cyc = 0;
    while (!prog_we && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic push_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[8];
    exp_t exp_q[$];
    exp_t e;
    int   lat, hi, cyc, bad, outstanding;
    logic prev_we;
    logic [24:0] ra;
    logic [7:0]  rd;

    tv[0] = '{25'h0000003,  8'hA5, 3, 1'b0, 2'd0, 22'h000001, 2'b01, 22'h000001};
    tv[1] = '{25'h00FFFFF,  8'h11, 1, 1'b0, 2'd0, 22'h07FFFF, 2'b01, 22'h07FFFF};
    tv[2] = '{25'h0100000,  8'h22, 2, 1'b0, 2'd1, 22'h000000, 2'b10, 22'h080000};
    tv[3] = '{25'h0300004,  8'h33, 1, 1'b0, 2'd3, 22'h000002, 2'b10, 22'h180002};
    tv[4] = '{25'h1F00010,  8'h3C, 0, 1'b1, 2'd0, 22'h000008, 2'b00, 22'h000008};
    tv[5] = '{25'h02FFFFF,  8'h44, 4, 1'b0, 2'd2, 22'h07FFFF, 2'b01, 22'h17FFFF};
    tv[6] = '{25'h1EFFFFF,  8'h55, 1, 1'b0, 2'd3, 22'h1FFFFF, 2'b01, 22'h37FFFF};
    tv[7] = '{25'h1F00000,  8'h66, 0, 1'b1, 2'd0, 22'h000000, 2'b00, 22'h000000};

    rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0; prog_rdy = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) tick();
    chk("rst_prog_we",   32'(prog_we),   0);
    chk("rst_prom_we",   32'(prom_we),   0);
    chk("rst_ovf",       32'(ovf),       0);
    chk("rst_prog_addr", 32'(prog_addr), 0);
    chk("rst_prog_data", 32'(prog_data), 0);
    chk("rst_prog_mask", 32'(prog_mask), 0);
    chk("rst_prog_ba",   32'(prog_ba),   0);
    chk("rst_busy",      32'(dwnld_busy), 0);
    chk("rst_busy1",     32'(dwnld_busy1), 0);
    chk("rst_ovf1",      32'(ovf1),      0);
    rst = 1'b0;
    tick();
    downloading = 1'b1;
    tick();

    // Vector table: decode, lane mask, latency and handshake length.
    for (int i = 0; i < 8; i++) begin
      push_byte(tv[i].a, tv[i].d);
      lat = 1;
      while (!prog_we && !prom_we && lat < 20) begin
        tick();
        lat++;
      end
      chk($sformatf("v%0d_latency", i), 32'(lat), 2);
      chk($sformatf("v%0d_prom_we", i),  32'(prom_we),  32'(tv[i].prom));
      chk($sformatf("v%0d_prom_we1", i), 32'(prom_we1), 32'(tv[i].prom));
      chk($sformatf("v%0d_addr", i),  32'(prog_addr),  32'(tv[i].pa));
      chk($sformatf("v%0d_addr1", i), 32'(prog_addr1), 32'(tv[i].pa1));
      chk($sformatf("v%0d_data", i),  32'(prog_data),  32'({tv[i].d, tv[i].d}));
      chk($sformatf("v%0d_data1", i), 32'(prog_data1), 32'({tv[i].d, tv[i].d}));
      if (!tv[i].prom) begin
        chk($sformatf("v%0d_ba", i),    32'(prog_ba),    32'(tv[i].ba));
        chk($sformatf("v%0d_ba1", i),   32'(prog_ba1),   0);
        chk($sformatf("v%0d_mask", i),  32'(prog_mask),  32'(tv[i].mask));
        chk($sformatf("v%0d_mask1", i), 32'(prog_mask1), 32'(tv[i].mask));
        handshake(tv[i].lat, hi);
        chk($sformatf("v%0d_we_cycles", i), 32'(hi), 32'(tv[i].lat));
        chk($sformatf("v%0d_we1_fall", i), 32'(prog_we1), 0);
        tick();
        chk($sformatf("v%0d_gap_low", i), 32'(prog_we), 0);
      end else begin
        bad = 0;
        tick();
        for (int k = 0; k < 3; k++) begin
          if (prog_we || prom_we) bad++;
          tick();
        end
        chk($sformatf("v%0d_prom_single", i), 32'(bad), 0);
      end
    end

    // Overflow: one write held in WRITE, then 10 back-to-back bytes.
    push_byte(25'h100000, 8'h80);
    wait_we(cyc);
    chk("ovf_prime_we", 32'(prog_we), 1);
    for (int i = 1; i <= 10; i++) begin
      ioctl_addr = 25'h100000 + 25'(2 * i);
      ioctl_dout = 8'(8'h80 + i);
      ioctl_wr   = 1'b1;
      tick();
      chk($sformatf("ovf_after_byte%0d", i), 32'(ovf), (i >= 9) ? 1 : 0);
    end
    ioctl_wr = 1'b0;
    chk("ovf_busy", 32'(dwnld_busy), 1);
    chk("ovf_held_addr", 32'(prog_addr), 0);
    chk("ovf_held_data", 32'(prog_data), 32'h8080);
    for (int j = 0; j <= 8; j++) begin
      wait_we(cyc);
      chk($sformatf("ovf_w%0d_we", j),   32'(prog_we), 1);
      chk($sformatf("ovf_w%0d_addr", j), 32'(prog_addr), 32'(j));
      chk($sformatf("ovf_w%0d_data", j), 32'(prog_data), 32'({2{8'(8'h80 + j)}}));
      handshake(1, hi);
    end
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (prog_we) bad++;
      tick();
    end
    chk("ovf_no_extra_writes", 32'(bad), 0);
    downloading = 1'b0;
    tick();
    chk("ovf_sticky", 32'(ovf), 1);
    chk("ovf_idle_busy", 32'(dwnld_busy), 0);
    downloading = 1'b1;
    tick();
    chk("ovf_cleared", 32'(ovf), 0);

    // Drain after downloading falls with three bytes queued.
    for (int k = 0; k < 3; k++) push_byte(25'h200000 + 25'(2 * k), 8'(8'hC0 + k));
    downloading = 1'b0;
    chk("drain_busy_start", 32'(dwnld_busy), 1);
    for (int k = 0; k < 3; k++) begin
      wait_we(cyc);
      chk($sformatf("drain%0d_we", k),   32'(prog_we), 1);
      chk($sformatf("drain%0d_ba", k),   32'(prog_ba), 2);
      chk($sformatf("drain%0d_addr", k), 32'(prog_addr), 32'(k));
      handshake(2, hi);
      chk($sformatf("drain%0d_cycles", k), 32'(hi), 2);
    end
    chk("drain_busy_gap", 32'(dwnld_busy), 1);
    tick();
    chk("drain_busy_end", 32'(dwnld_busy), 0);

    // Reset in the middle of a write with more bytes queued.
    downloading = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) push_byte(25'h000010 + 25'(2 * k), 8'(8'hE0 + k));
    chk("rstw_in_write", 32'(prog_we), 1);
    #1;
    rst = 1'b1;
    downloading = 1'b0;
    #1;
    chk("rstw_we_now", 32'(prog_we), 0);
    chk("rstw_busy_now", 32'(dwnld_busy), 0);
    tick();
    rst = 1'b0;
    ioctl_addr = 25'h000020;
    ioctl_wr = 1'b1;
    tick();
    tick();
    ioctl_wr = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (prog_we || prom_we || dwnld_busy) bad++;
      tick();
    end
    chk("rstw_quiet_after", 32'(bad), 0);

    // Randomised traffic against the reference model.
    downloading = 1'b1;
    prev_we = 1'b0;
    outstanding = 0;
    tick();
    for (int c = 0; c < 1700; c++) begin
      if (prom_we) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL rnd_unexpected_prom: got prom_we want none");
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rnd%0d_kind", c), 32'(e.prom), 1);
          chk($sformatf("rnd%0d_paddr", c), 32'(prog_addr), 32'(e.paddr));
          chk($sformatf("rnd%0d_pdata", c), 32'(prog_data), 32'(e.data));
        end
        outstanding--;
      end
      if (prog_we && !prev_we) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL rnd_unexpected_write: got prog_we want none");
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rnd%0d_kind", c), 32'(e.prom), 0);
          chk($sformatf("rnd%0d_ba", c),   32'(prog_ba),   32'(e.ba));
          chk($sformatf("rnd%0d_addr", c), 32'(prog_addr), 32'(e.paddr));
          chk($sformatf("rnd%0d_data", c), 32'(prog_data), 32'(e.data));
          chk($sformatf("rnd%0d_mask", c), 32'(prog_mask), 32'(e.mask));
        end
      end
      if (!prog_we && prev_we) outstanding--;
      prev_we = prog_we;
      prog_rdy = ($urandom_range(0, 2) == 0);
      if (c < 1500 && outstanding < 6 && $urandom_range(0, 1) == 1) begin
        ra = rnd_addr();
        rd = 8'($urandom);
        ioctl_addr = ra;
        ioctl_dout = rd;
        ioctl_wr   = 1'b1;
        exp_q.push_back(ref_model(ra, rd, 4));
        outstanding++;
      end else begin
        ioctl_wr = 1'b0;
      end
      tick();
    end
    ioctl_wr = 1'b0;
    prog_rdy = 1'b0;
    chk("rnd_queue_empty", 32'(exp_q.size()), 0);
    chk("rnd_outstanding", 32'(outstanding), 0);
    chk("rnd_no_ovf", 32'(ovf), 0);
    downloading = 1'b0;
    tick();
    chk("rnd_busy_end", 32'(dwnld_busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
